// File: rtl/data_sram_responder_pkg.sv
// data_sram_responder_pkg: shared size codes, LFSR seed and entry-width helpers
package data_sram_responder_pkg;
  localparam logic [1:0] SRAM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] SRAM_SIZE_HALF = 2'b01;
  localparam logic [1:0] SRAM_SIZE_WORD = 2'b10;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  function automatic int cd_width(input int latency);
    return latency > 1 ? $clog2(latency) : 1;
  endfunction
  function automatic int rsp_entry_width(input int latency);
    return 1 + 32 + cd_width(latency);
  endfunction
endpackage

// File: rtl/data_sram_responder_if.sv
// data_sram_if: SRAM-like data bus between the execute stage and its responder
interface data_sram_if;
  logic req;
  logic wr;
  logic [1:0] size;
  logic [3:0] wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic addr_ok;
  logic data_ok;
  logic [31:0] rdata;
  modport master(output req, wr, size, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave(input req, wr, size, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/data_sram_responder_rsp_fifo.sv
// rsp_fifo: in-order pending-response queue; each entry carries {wr, data, countdown}
module rsp_fifo
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        push_wr,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output logic        head_wr,
  output logic [31:0] head_data,
  output logic        head_due
);
  localparam int CW = cd_width(LATENCY);
  localparam int EW = rsp_entry_width(LATENCY);
  localparam int CNW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] rp, wp;
  logic [CNW-1:0] count;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  // pointers and occupancy; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      rp <= '0;
      wp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= nxt(wp);
      if (pop) rp <= nxt(rp);
      count <= count + CNW'(push) - CNW'(pop);
    end
  end
  // countdowns saturate at zero; the accept edge itself counts as the first cycle,
  // so a new entry starts at LATENCY-1 and becomes due exactly LATENCY cycles later
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++)
      if (mem[i][CW-1:0] != '0) mem[i][CW-1:0] <= mem[i][CW-1:0] - 1'b1;
    if (push) mem[wp] <= {push_wr, push_data, CW'(LATENCY - 1)};
  end
  assign full = count == CNW'(DEPTH);
  assign empty = count == '0;
  assign {head_wr, head_data} = mem[rp][EW-1:CW];
  assign head_due = mem[rp][CW-1:0] == '0;
endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder: SRAM-like data slave with byte-strobe RAM; DATA_SRAM_RAND_STALL_EN adds LFSR addr_ok stalls
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH = 2,
  parameter int LATENCY = 1
) (
  input logic clk,
  input logic reset,
  data_sram_if.slave data_sram
);
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic accept, room, full, empty, head_wr, head_due, unused_bits;
  logic [31:0] head_data;
  assign idx = data_sram.addr[ADDR_WIDTH+1:2];
  assign unused_bits = ^{data_sram.size, data_sram.addr[1:0], data_sram.addr[31:ADDR_WIDTH+2]};
  assign room = ~reset & ~full;
`ifdef DATA_SRAM_RAND_STALL_EN
  logic [15:0] lfsr;
  // Fibonacci LFSR x^16+x^14+x^13+x^11+1 driving pseudo-random address backpressure
  always_ff @(posedge clk) begin
    lfsr <= reset ? LFSR_SEED : {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign data_sram.addr_ok = room & ~lfsr[0];
`else
  assign data_sram.addr_ok = room;
`endif
  assign accept = data_sram.req & data_sram.addr_ok;
  // byte-lane writes land at the accept edge; contents survive reset
  always_ff @(posedge clk) begin
    if (accept & data_sram.wr)
      for (int i = 0; i < 4; i++)
        if (data_sram.wstrb[i]) mem[idx][8*i +: 8] <= data_sram.wdata[8*i +: 8];
  end
  rsp_fifo #(.DEPTH(DEPTH), .LATENCY(LATENCY)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(accept),
    .push_wr(data_sram.wr),
    .push_data(data_sram.wr ? 32'h0 : mem[idx]),
    .pop(data_sram.data_ok),
    .full(full),
    .empty(empty),
    .head_wr(head_wr),
    .head_data(head_data),
    .head_due(head_due)
  );
  assign data_sram.data_ok = ~reset & ~empty & head_due;
  assign data_sram.rdata = data_sram.data_ok & ~head_wr ? head_data : 32'h0;
endmodule
